// File: rtl/fifo_drain_stream.sv
// Read-side companion to fifo_sync: drains buffered Q31 samples into fixed-length
// frames on a valid/ready stream, hiding the FIFO's one-cycle read latency.
module fifo_drain_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int BURST_LEN   = 8,
  parameter int START_LEVEL = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic [FIFO_DEPTH-1:0] fifo_level,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0]         BURST     = CW'(BURST_LEN);
  localparam logic [FIFO_DEPTH-1:0] START_LVL = FIFO_DEPTH'(START_LEVEL);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         issued_q, delivered_q, target_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
  logic [1:0]            count_q;
  logic                  rd_pending_q;
  logic                  push, pop, start, early_end, frame_done;
  logic [2:0]            occ_after;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = buf0_q;
  assign pop     = m_valid && m_ready;
  assign push    = rd_pending_q;
  assign m_last  = m_valid && (delivered_q == target_q - CW'(1));
  assign busy    = (state_q != IDLE);

  // Occupancy the buffer will have once everything already in flight has landed.
  assign occ_after  = {1'b0, count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
  assign fifo_rd_en = (state_q == STREAM) && !fifo_empty && (issued_q < BURST) &&
                      (occ_after < 3'd2);

  assign start      = !fifo_empty && ((enable && fifo_level >= START_LVL) || flush);
  assign early_end  = flush && fifo_empty && (issued_q != '0);
  // The second term closes a short frame whose beats all left before the flush.
  assign frame_done = (state_q == DRAIN) &&
                      ((pop && delivered_q == target_q - CW'(1)) || delivered_q == target_q);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if ((fifo_rd_en && issued_q == BURST - CW'(1)) || early_end) state_d = DRAIN;
      DRAIN:   if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the buffer is reset too so
  // m_data reads zero after reset rather than stale samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fifo_cs      <= 1'b0;
      rd_pending_q <= 1'b0;
      count_q      <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      issued_q     <= '0;
      delivered_q  <= '0;
      target_q     <= '0;
      frame_count  <= 16'd0;
    end else begin
      fifo_cs      <= 1'b1;
      state_q      <= state_d;
      rd_pending_q <= fifo_rd_en;

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) buf0_q <= fifo_data_out;
          else                 buf1_q <= fifo_data_out;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          buf0_q  <= buf1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            buf0_q <= fifo_data_out;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= fifo_data_out;
          end
        end
        default: ;
      endcase

      if (state_q == IDLE && state_d == STREAM) begin
        issued_q    <= '0;
        delivered_q <= '0;
        target_q    <= BURST;
      end else begin
        if (fifo_rd_en) issued_q <= issued_q + CW'(1);
        if (pop)        delivered_q <= delivered_q + CW'(1);
        if (state_q == STREAM && early_end) target_q <= issued_q;
      end

      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
